// File: rtl/tgate_bus_arbiter.sv
// tgate_bus_arbiter: round-robin break-before-make arbiter driving N transmission-gate bus switches
module tgate_bus_arbiter #(
  parameter int N        = 4,
  parameter int DEAD     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [N-1:0] ncontrol,
  output logic [N-1:0] pcontrol,
  output logic         busy
);
  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int DW = $clog2(DEAD + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          others, rel;

  assign others   = |(req & ~grant_q);
  assign rel      = !req[ptr_q] || (hold_q == HW'(MAX_HOLD) && others);
  assign grant    = grant_q;
  assign ncontrol = grant_q;
  assign pcontrol = ~grant_q;
  assign busy     = busy_q;

  // first requester after the pointer wins; scanning backwards lets the nearest one overwrite
  always_comb begin
    win = ptr_q;
    for (int i = N; i >= 1; i--)
      if (req[PW'((int'(ptr_q) + i) % N)]) win = PW'((int'(ptr_q) + i) % N);
  end

  // IDLE -> ON -> GAP sequencing with saturating hold count and dead-time countdown
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    grant_d = grant_q;
    case (state_q)
      ON: begin
        hold_d  = rel ? '0 : (hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + HW'(1));
        dead_d  = rel ? DW'(DEAD) : dead_q;
        grant_d = rel ? '0 : grant_q;
        state_d = rel ? GAP : ON;
      end
      GAP: begin
        dead_d  = dead_q - DW'(1);
        state_d = dead_q != DW'(1) ? GAP : (|req ? ON : IDLE);
        ptr_d   = state_d == ON ? win : ptr_q;
        hold_d  = state_d == ON ? HW'(1) : hold_q;
        grant_d = state_d == ON ? N'(1) << win : '0;
      end
      default: begin
        state_d = |req ? ON : IDLE;
        ptr_d   = |req ? win : ptr_q;
        hold_d  = |req ? HW'(1) : '0;
        grant_d = |req ? N'(1) << win : '0;
      end
    endcase
    busy_d = state_d != IDLE;
  end

  // register all state and outputs; reset parks the pointer so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N - 1);
      hold_q  <= '0;
      dead_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// tb_tgate_bus_arbiter: directed self-checking bench for tgate_bus_arbiter
module tb_tgate_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant, ncontrol, pcontrol;
  logic       busy;
  int checks = 0;
  int failures = 0;
  logic [3:0] prev = 4'b0000;

  tgate_bus_arbiter #(.N(4), .DEAD(2), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .ncontrol(ncontrol), .pcontrol(pcontrol), .busy(busy)
  );

  always #5 clk = ~clk;

  // invariants checked away from the active edge every cycle
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grant)) begin
      failures++;
      $display("FAIL onehot0 grant=%b", grant);
    end
    checks++;
    if (pcontrol !== ~ncontrol || ncontrol !== grant) begin
      failures++;
      $display("FAIL gate_pair grant=%b ncontrol=%b pcontrol=%b", grant, ncontrol, pcontrol);
    end
    checks++;
    if (prev != 4'b0 && grant != 4'b0 && grant !== prev) begin
      failures++;
      $display("FAIL overlap prev=%b grant=%b", prev, grant);
    end
    prev = grant;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (grant !== 4'b0000 || pcontrol !== 4'b1111 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold grant=%b pcontrol=%b busy=%b want 0000/1111/0", grant, pcontrol, busy);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release grant=%b busy=%b want 0001/1", grant, busy);
    end
    pulse_reset();
  endtask

  task automatic test_single();
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (grant !== 4'b0001 || pcontrol !== 4'b1110 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_grant cyc=%0d grant=%b pcontrol=%b busy=%b want 0001/1110/1", i, grant, pcontrol, busy);
      end
    end
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_gap cyc=%0d grant=%b busy=%b want 0000/1", i, grant, busy);
      end
    end
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  task automatic test_round_robin();
    int owners [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    pulse_reset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      exp = 4'b0001 << owners[o];
      for (int c = 0; c < 16; c++) begin
        step();
        checks++;
        if (grant !== exp) begin
          failures++;
          $display("FAIL rr_hold owner=%0d cyc=%0d grant=%b want %b", owners[o], c, grant, exp);
        end
      end
      if (o < 4)
        for (int c = 0; c < 2; c++) begin
          step();
          checks++;
          if (grant !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rr_gap after=%0d cyc=%0d grant=%b busy=%b want 0000/1", owners[o], c, grant, busy);
          end
        end
    end
  endtask

  task automatic test_no_contention();
    pulse_reset();
    req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (grant !== 4'b0100 || busy !== 1'b1) begin
        failures++;
        $display("FAIL solo_hold cyc=%0d grant=%b busy=%b want 0100/1", c, grant, busy);
      end
    end
  endtask

  task automatic test_handover();
    req = 4'b0001;
    step();
    step();
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL handover_setup grant=%b want 0001", grant);
    end
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (grant !== 4'b0000) begin
        failures++;
        $display("FAIL handover_gap cyc=%0d grant=%b want 0000", c, grant);
      end
    end
    step();
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL handover_new grant=%b want 0100", grant);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b1000;
    step();
    step();
    step();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_setup grant=%b want 1000", grant);
    end
    rst = 1'b1;
    req = 4'b1001;
    step();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || pcontrol !== 4'b1111) begin
      failures++;
      $display("FAIL midrst_off grant=%b busy=%b pcontrol=%b want 0000/0/1111", grant, busy, pcontrol);
    end
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_ptr grant=%b want 0001", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_contention();
    test_handover();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
